// File: rtl/port_arb4.sv
// port_arb4: 4-requester round-robin arbiter with a hold limit. It drives the
// one-hot grant and the select/enable of a shared 4:1 mux.
// Latency: a request seen in cycle N is granted from cycle N+1. An owner hands over
// with no idle bubble. Backpressure: a requester holds req high until it is granted.
// Once the owner has held the grant for MAX_HOLD cycles, it is preempted in favour
// of any waiting requester.
//
// Ports:
//   clk      single clock; all state changes on its rising edge
//   rst_n    asynchronous active-low reset
//   req      per-requester request; held high for the whole transaction
//   gnt      registered one-hot grant; 0 when nobody owns the resource
//   sel      registered binary owner index; in IDLE it holds the last owner
//   en       registered mux enable; equals |gnt
//   preempt  registered one-cycle pulse on a grant change forced by MAX_HOLD
module port_arb4 #(
  parameter int MAX_HOLD = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] req,
  output logic [3:0] gnt,
  output logic [1:0] sel,
  output logic       en,
  output logic       preempt
);

  localparam logic [7:0] HOLD_LIMIT = 8'(MAX_HOLD);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_OWN  = 1'b1
  } state_t;

  state_t     r_state;
  logic [1:0] r_ptr;      // last winner; the search starts at r_ptr+1
  logic [7:0] r_cnt;      // cycles owned by the current owner, saturating
  logic [3:0] r_gnt;
  logic [1:0] r_sel;
  logic       r_en;
  logic       r_preempt;

  logic [3:0] w_others;   // requesters competing against the current owner
  logic       w_own_req;  // current owner still requesting
  logic       w_expired;  // owner has reached its hold limit
  logic [1:0] w_pick;     // round-robin winner among w_others
  logic [3:0] w_pick_oh;

  // Search order is ptr+1, ptr+2, ptr+3, ptr. Wrapping comes from the 2-bit add.
  function automatic logic [1:0] rr_pick(input logic [3:0] mask, input logic [1:0] ptr);
    logic [1:0] idx;
    logic       found;
    rr_pick = ptr;
    found   = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      idx = ptr + i[1:0];
      if (!found && mask[idx]) begin
        rr_pick = idx;
        found   = 1'b1;
      end
    end
  endfunction

  always_comb begin
    // r_gnt is zero in IDLE, so there w_others is simply req.
    w_others  = req & ~r_gnt;
    w_own_req = |(req & r_gnt);
    w_expired = (r_cnt == HOLD_LIMIT);
    w_pick    = rr_pick(w_others, r_ptr);
    w_pick_oh = 4'b0001 << w_pick;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_ptr     <= 2'd3;
      r_cnt     <= 8'd0;
      r_gnt     <= 4'b0000;
      r_sel     <= 2'd0;
      r_en      <= 1'b0;
      r_preempt <= 1'b0;
    end else begin
      r_preempt <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (|req) begin
            r_state <= S_OWN;
            r_gnt   <= w_pick_oh;
            r_sel   <= w_pick;
            r_ptr   <= w_pick;
            r_en    <= 1'b1;
            r_cnt   <= 8'd1;
          end
        end
        S_OWN: begin
          if (w_own_req && !(w_expired && (|w_others))) begin
            // Keep the owner. The counter saturates so a later request can still preempt.
            if (!w_expired) r_cnt <= r_cnt + 8'd1;
          end else if (|w_others) begin
            // The owner either released or is being preempted; hand over directly.
            r_gnt     <= w_pick_oh;
            r_sel     <= w_pick;
            r_ptr     <= w_pick;
            r_cnt     <= 8'd1;
            r_preempt <= w_own_req;
          end else begin
            // Nobody is left. sel keeps the last owner index.
            r_state <= S_IDLE;
            r_gnt   <= 4'b0000;
            r_en    <= 1'b0;
            r_cnt   <= 8'd0;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_gnt   <= 4'b0000;
          r_en    <= 1'b0;
        end
      endcase
    end
  end

  assign gnt     = r_gnt;
  assign sel     = r_sel;
  assign en      = r_en;
  assign preempt = r_preempt;

endmodule

// File: tb/tb_port_arb4.sv
module tb_port_arb4;

  localparam int MAXH = 4;

  logic       clk;
  logic       rst_n;
  logic [3:0] req;
  logic [3:0] gnt;
  logic [1:0] sel;
  logic       en;
  logic       preempt;

  int checks = 0;
  int errors = 0;

  // Reference model: who owns, who won last, how long the owner has held, last select.
  int         m_owner;
  int         m_last;
  int         m_held;
  int         m_sel;
  logic       m_pre;

  port_arb4 #(.MAX_HOLD(MAXH)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .req     (req),
    .gnt     (gnt),
    .sel     (sel),
    .en      (en),
    .preempt (preempt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic model_reset();
    m_owner = -1;
    m_last  = 3;
    m_held  = 0;
    m_sel   = 0;
    m_pre   = 1'b0;
  endtask

  // One rising edge of the arbiter, applied to the request seen in the deciding cycle.
  task automatic model_clock(input logic [3:0] r);
    int         nxt;
    int         c;
    logic [3:0] others;
    nxt    = -1;
    m_pre  = 1'b0;
    others = r;
    if (m_owner >= 0) others[m_owner] = 1'b0;
    if (m_owner >= 0 && r[m_owner] && !(m_held == MAXH && others != 4'b0000)) begin
      if (m_held < MAXH) m_held = m_held + 1;
    end else begin
      for (int k = 1; k <= 4; k++) begin
        c = (m_last + k) % 4;
        if (nxt < 0 && others[c]) nxt = c;
      end
      if (nxt >= 0) begin
        m_pre   = (m_owner >= 0) && r[m_owner];
        m_owner = nxt;
        m_last  = nxt;
        m_sel   = nxt;
        m_held  = 1;
      end else begin
        m_owner = -1;
        m_held  = 0;
      end
    end
  endtask

  function automatic logic [3:0] exp_gnt();
    logic [3:0] g;
    g = 4'b0000;
    if (m_owner >= 0) g[m_owner] = 1'b1;
    return g;
  endfunction

  function automatic int owner_of(input logic [3:0] g);
    int o;
    o = -1;
    for (int i = 0; i < 4; i++) if (g[i]) o = i;
    return o;
  endfunction

  // Drive a request for one cycle. Returns 1 ns after the rising edge.
  task automatic step(input logic [3:0] r);
    req = r;
    @(posedge clk);
    model_clock(r);
    #1;
  endtask

  task automatic do_reset();
    req   = 4'b0000;
    rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    model_reset();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    req   = 4'b0000;
    rst_n = 1'b0;
    #2;
    model_reset();
    checks++;
    if (gnt !== 4'b0000 || sel !== 2'b00 || en !== 1'b0 || preempt !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs: got gnt=%b sel=%b en=%b pre=%b want 0000 00 0 0", gnt, sel, en, preempt);
    end
    @(negedge clk);
    rst_n = 1'b1;
    step(4'b0000);
    checks++;
    if (gnt !== 4'b0000 || en !== 1'b0) begin
      errors++;
      $display("FAIL idle_no_req: got gnt=%b en=%b want 0000 0", gnt, en);
    end
  endtask

  task automatic test_single();
    do_reset();
    step(4'b0001);
    checks++;
    if (gnt !== 4'b0001 || sel !== 2'b00 || en !== 1'b1) begin
      errors++;
      $display("FAIL single_req0: got gnt=%b sel=%b en=%b want 0001 00 1", gnt, sel, en);
    end
  endtask

  task automatic test_rotation();
    int         exp_seq[5] = '{0, 1, 2, 3, 0};
    int         seen[$];
    int         prev;
    logic [3:0] r;
    do_reset();
    prev = -1;
    for (int cyc = 0; cyc < 10; cyc++) begin
      r = 4'b1111;
      if (m_owner >= 0 && m_held >= 2) r[m_owner] = 1'b0;
      step(r);
      if (owner_of(gnt) != prev) begin
        seen.push_back(owner_of(gnt));
        prev = owner_of(gnt);
      end
      checks++;
      if (en !== 1'b1 || gnt !== exp_gnt()) begin
        errors++;
        $display("FAIL rotation_cycle%0d: got gnt=%b en=%b want %b 1", cyc, gnt, en, exp_gnt());
      end
    end
    checks++;
    if (seen.size() != 5) begin
      errors++;
      $display("FAIL rotation_count: got %0d owners want 5", seen.size());
    end else begin
      for (int i = 0; i < 5; i++) begin
        checks++;
        if (seen[i] != exp_seq[i]) begin
          errors++;
          $display("FAIL rotation_order%0d: got owner %0d want %0d", i, seen[i], exp_seq[i]);
        end
      end
    end
  endtask

  task automatic test_preempt();
    int own_cycles;
    do_reset();
    own_cycles = 0;
    step(4'b0001);
    if (gnt === 4'b0001) own_cycles++;
    step(4'b0001);
    if (gnt === 4'b0001) own_cycles++;
    // req2 appears during owned cycle 2.
    for (int i = 0; i < 2; i++) begin
      step(4'b0101);
      if (gnt === 4'b0001) own_cycles++;
      checks++;
      if (preempt !== 1'b0) begin
        errors++;
        $display("FAIL preempt_early%0d: got pre=%b want 0", i, preempt);
      end
    end
    step(4'b0101);
    checks++;
    if (own_cycles != 4) begin
      errors++;
      $display("FAIL preempt_hold_len: got %0d cycles want 4", own_cycles);
    end
    checks++;
    if (gnt !== 4'b0100 || sel !== 2'b10 || preempt !== 1'b1) begin
      errors++;
      $display("FAIL preempt_switch: got gnt=%b sel=%b pre=%b want 0100 10 1", gnt, sel, preempt);
    end
    step(4'b0101);
    checks++;
    if (gnt !== 4'b0100 || preempt !== 1'b0) begin
      errors++;
      $display("FAIL preempt_pulse: got gnt=%b pre=%b want 0100 0", gnt, preempt);
    end
  endtask

  task automatic test_saturate();
    int bad;
    do_reset();
    bad = 0;
    for (int cyc = 0; cyc < 20; cyc++) begin
      step(4'b0010);
      if (gnt !== 4'b0010 || preempt !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL saturate_hold: got %0d bad cycles want 0", bad);
    end
    step(4'b1010);
    checks++;
    if (gnt !== 4'b1000 || sel !== 2'b11 || preempt !== 1'b1) begin
      errors++;
      $display("FAIL saturate_late_preempt: got gnt=%b sel=%b pre=%b want 1000 11 1", gnt, sel, preempt);
    end
  endtask

  task automatic test_idle_return();
    do_reset();
    step(4'b0100);
    step(4'b0100);
    step(4'b0000);
    checks++;
    if (gnt !== 4'b0000 || en !== 1'b0 || sel !== 2'b10) begin
      errors++;
      $display("FAIL idle_return: got gnt=%b en=%b sel=%b want 0000 0 10", gnt, en, sel);
    end
    step(4'b0000);
    checks++;
    if (sel !== 2'b10 || en !== 1'b0) begin
      errors++;
      $display("FAIL idle_sel_hold: got sel=%b en=%b want 10 0", sel, en);
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    step(4'b0100);
    checks++;
    if (gnt !== 4'b0100) begin
      errors++;
      $display("FAIL async_setup: got gnt=%b want 0100", gnt);
    end
    // Assert reset well clear of any clock edge.
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    checks++;
    if (gnt !== 4'b0000 || en !== 1'b0 || sel !== 2'b00) begin
      errors++;
      $display("FAIL async_clear: got gnt=%b en=%b sel=%b want 0000 0 00", gnt, en, sel);
    end
    req = 4'b0000;
    @(negedge clk);
    rst_n = 1'b1;
    step(4'b0000);
    checks++;
    if (gnt !== 4'b0000 || en !== 1'b0) begin
      errors++;
      $display("FAIL post_reset_quiet: got gnt=%b en=%b want 0000 0", gnt, en);
    end
    step(4'b1111);
    checks++;
    if (gnt !== 4'b0001) begin
      errors++;
      $display("FAIL post_reset_prio: got gnt=%b want 0001", gnt);
    end
  endtask

  task automatic test_random();
    logic [3:0] r;
    logic [3:0] prev_r;
    do_reset();
    r = 4'b0000;
    for (int cyc = 0; cyc < 400; cyc++) begin
      for (int b = 0; b < 4; b++) if ($urandom_range(0, 3) == 0) r[b] = ~r[b];
      prev_r = r;
      step(r);
      checks++;
      if (gnt !== exp_gnt() || sel !== 2'(m_sel) || en !== (m_owner >= 0) || preempt !== m_pre) begin
        errors++;
        $display("FAIL random_cycle%0d: got gnt=%b sel=%b en=%b pre=%b want %b %0d %0d %b", cyc, gnt, sel, en, preempt, exp_gnt(), m_sel, (m_owner >= 0), m_pre);
      end
      checks++;
      if ($countones(gnt) > 1 || (gnt & ~prev_r) != 4'b0000) begin
        errors++;
        $display("FAIL random_legal%0d: got gnt=%b with req=%b want one-hot subset", cyc, gnt, prev_r);
      end
    end
  endtask

  initial begin
    rst_n = 1'b0;
    req   = 4'b0000;
    model_reset();
    test_reset();
    test_single();
    test_rotation();
    test_preempt();
    test_saturate();
    test_idle_return();
    test_async_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/port_arb4.md
PORT_ARB4 -- requirements
Module: port_arb4

Interface
REQ-001 SHALL have parameter MAX_HOLD, default 8, meaning the maximum number of consecutive cycles one requester keeps the grant while another requester waits; legal range 1..255.
REQ-002 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n, input, 1, reset, asynchronous and active-low.
REQ-004 SHALL have port req, input, 4, per-requester request; a requester holds its bit high for its whole transaction.
REQ-005 SHALL have port gnt, output, 4, registered one-hot grant; all zeros when nobody owns the resource.
REQ-006 SHALL have port sel, output, 2, registered binary index of the current owner, wired to the shared 4:1 mux select.
REQ-007 SHALL have port en, output, 1, registered mux enable; equals OR of gnt.
REQ-008 SHALL have port preempt, output, 1, registered single-cycle pulse marking a grant change forced by MAX_HOLD.

Function
REQ-009 SHALL implement two states: IDLE (no owner) and OWN (exactly one owner).
REQ-010 SHALL hold a 2-bit last-winner pointer; arbitration priority starts at pointer+1 mod 4 and proceeds upward with wrap-around.
REQ-011 SHALL, in IDLE with any req bit set in cycle N, enter OWN with gnt/sel/en showing the winner from cycle N+1 (1-cycle latency).
REQ-012 SHALL, in IDLE with req == 0, stay in IDLE with gnt = 0 and en = 0.
REQ-013 SHALL keep the owner while its req bit stays high and no preemption applies.
REQ-014 SHALL, when the owner's req bit is low in cycle N, arbitrate among the other requesters in cycle N and grant the winner from N+1 with no idle bubble; if none is requesting, return to IDLE at N+1.
REQ-015 SHALL count owned cycles in an 8-bit hold counter, loaded with 1 on every new grant and incremented while ownership continues, saturating at MAX_HOLD.
REQ-016 SHALL preempt when the counter equals MAX_HOLD, the owner still requests, and any other req bit is set; grant passes at the next edge to the next other requester in round-robin order, and preempt pulses high for that one cycle.
REQ-017 SHALL, when the counter equals MAX_HOLD and no other requester is waiting, keep the owner with the counter saturated; preemption fires on the first later cycle in which another request appears.
REQ-018 SHALL update the pointer to the new owner on every grant.
REQ-019 SHALL hold sel at the last owner's index while in IDLE, with en = 0.
REQ-020 SHALL never assert more than one gnt bit, and SHALL never assert gnt to a requester whose req was low in the deciding cycle.
REQ-021 SHALL treat a preempted owner that keeps requesting as an ordinary waiting requester.

Reset
REQ-022 SHALL, while rst_n is low, force gnt = 0000, sel = 00, en = 0, preempt = 0, state IDLE, counter 0, and pointer 3 (so requester 0 has first priority).
REQ-023 SHALL take reset effect immediately even mid-transaction, with no grant issued on the first edge after rst_n rises unless req is set in that cycle.

Verification
REQ-024 Bench SHALL check reset then req = 0001 at cycle 0 -> gnt = 0001, sel = 00, en = 1 at cycle 1.
REQ-025 Bench SHALL check from reset, req = 1111 held, with each owner dropping req after 2 owned cycles -> owners 0,1,2,3,0 in order, with no cycle where en = 0.
REQ-026 Bench SHALL check MAX_HOLD = 4, req0 held continuously, req2 raised at owned cycle 2 -> req0 owns 4 cycles, then gnt = 0100 with preempt = 1 for one cycle.
REQ-027 Bench SHALL check req1 alone held for 20 cycles with MAX_HOLD = 4 -> gnt stays 0010 and preempt never fires; req3 raised at cycle 20 -> gnt = 1000 at cycle 21.
REQ-028 Bench SHALL check owner 2 drops req with req = 0000 -> next cycle gnt = 0000, en = 0, sel = 10 held.
REQ-029 Bench SHALL check rst_n driven low asynchronously between edges while gnt = 0100 -> gnt, en, sel clear without waiting for a clock edge; after release, req = 1111 -> gnt = 0001.
